// File: rtl/maxpool_engine_if.sv
// Bus bundle for the 2x2 max-pooling stage: start/done handshake, feature-map
// read port and pooled-result write port.
interface maxpool_engine_if #(
    parameter int DATA_W = 32,
    parameter int RD_AW  = 6,
    parameter int WR_AW  = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic              fm_rd_en;
    logic [RD_AW-1:0]  fm_rd_addr;
    logic [DATA_W-1:0] fm_rd_data;
    logic              pool_wr_en;
    logic [WR_AW-1:0]  pool_wr_addr;
    logic [DATA_W-1:0] pool_wr_data;

    // The pooling engine drives the memory ports and status.
    modport master (
        input  start, fm_rd_data,
        output busy, done, fm_rd_en, fm_rd_addr,
               pool_wr_en, pool_wr_addr, pool_wr_data
    );

    modport slave (
        output start, fm_rd_data,
        input  busy, done, fm_rd_en, fm_rd_addr,
               pool_wr_en, pool_wr_addr, pool_wr_data
    );
endinterface

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max-pooling engine: reads each window from a synchronous
// feature-map port, tracks the signed maximum and writes one word per window.
module maxpool_engine #(
    parameter int FM_WIDTH  = 6,
    parameter int FM_HEIGHT = 6,
    parameter int DATA_W    = 32,
    parameter int RD_AW     = 6,
    parameter int WR_AW     = 4
) (
    input logic             clk,
    input logic             rst,
    maxpool_engine_if.master bus
);
    localparam int PW = FM_WIDTH / 2;
    localparam int PH = FM_HEIGHT / 2;
    localparam logic [WR_AW-1:0] PC_LAST = WR_AW'(PW - 1);
    localparam logic [WR_AW-1:0] PR_LAST = WR_AW'(PH - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, LAST, WRITE, DONE} state_t;

    state_t                    state, state_n;
    logic [1:0]                rd_cnt, rd_cnt_n;
    logic [WR_AW-1:0]          pr, pc, pr_n, pc_n;
    logic signed [DATA_W-1:0]  max_reg, max_n, data_in;
    logic                      rd_en_n, wr_en_n, busy_n, done_n;
    logic [RD_AW-1:0]          rd_addr_n;
    logic [WR_AW-1:0]          wr_addr_n;
    logic [DATA_W-1:0]         wr_data_n;

    assign data_in = bus.fm_rd_data;

    // Read k of window (r,c): k[0] selects the column, k[1] the row.
    function automatic logic [RD_AW-1:0] win_addr(input logic [WR_AW-1:0] r,
                                                  input logic [WR_AW-1:0] c,
                                                  input logic [1:0]       k);
        int a;
        a = 2 * int'(r) * FM_WIDTH + 2 * int'(c)
          + (k[1] ? FM_WIDTH : 0) + int'(k[0]);
        return RD_AW'(a);
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        rd_cnt_n  = rd_cnt;
        pr_n      = pr;
        pc_n      = pc;
        max_n     = max_reg;
        rd_en_n   = 1'b0;
        rd_addr_n = bus.fm_rd_addr;
        wr_en_n   = 1'b0;
        wr_addr_n = bus.pool_wr_addr;
        wr_data_n = bus.pool_wr_data;
        busy_n    = bus.busy;
        done_n    = bus.done;

        // Data returns one cycle after each read; the first sample loads outright.
        if ((state == ISSUE && rd_cnt != 2'd0) || state == LAST) begin
            if (state == ISSUE && rd_cnt == 2'd1)
                max_n = data_in;
            else if (data_in > max_reg)
                max_n = data_in;
        end

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n   = ISSUE;
                    rd_cnt_n  = 2'd0;
                    pr_n      = '0;
                    pc_n      = '0;
                    rd_en_n   = 1'b1;
                    rd_addr_n = win_addr('0, '0, 2'd0);
                    busy_n    = 1'b1;
                    done_n    = 1'b0;
                end
            end
            ISSUE: begin
                if (rd_cnt == 2'd3) begin
                    state_n  = LAST;
                    rd_cnt_n = 2'd0;
                end else begin
                    rd_cnt_n  = rd_cnt + 2'd1;
                    rd_en_n   = 1'b1;
                    rd_addr_n = win_addr(pr, pc, rd_cnt + 2'd1);
                end
            end
            LAST: begin
                state_n   = WRITE;
                wr_en_n   = 1'b1;
                wr_addr_n = WR_AW'(int'(pr) * PW + int'(pc));
                wr_data_n = max_n;
            end
            WRITE: begin
                if (pr == PR_LAST && pc == PC_LAST) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    if (pc == PC_LAST) begin
                        pc_n = '0;
                        pr_n = pr + WR_AW'(1);
                    end else begin
                        pc_n = pc + WR_AW'(1);
                    end
                    state_n   = ISSUE;
                    rd_en_n   = 1'b1;
                    rd_addr_n = win_addr(pr_n, pc_n, 2'd0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rd_cnt           <= '0;
            pr               <= '0;
            pc               <= '0;
            max_reg          <= '0;
            bus.fm_rd_en     <= 1'b0;
            bus.fm_rd_addr   <= '0;
            bus.pool_wr_en   <= 1'b0;
            bus.pool_wr_addr <= '0;
            bus.pool_wr_data <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            state            <= state_n;
            rd_cnt           <= rd_cnt_n;
            pr               <= pr_n;
            pc               <= pc_n;
            max_reg          <= max_n;
            bus.fm_rd_en     <= rd_en_n;
            bus.fm_rd_addr   <= rd_addr_n;
            bus.pool_wr_en   <= wr_en_n;
            bus.pool_wr_addr <= wr_addr_n;
            bus.pool_wr_data <= wr_data_n;
            bus.busy         <= busy_n;
            bus.done         <= done_n;
        end
    end
endmodule

// File: doc/maxpool_engine.md
# maxpool_engine

2x2, stride-2 max-pooling stage directly downstream of the 3x3 convolution engine. After the convolution engine asserts done, it is started on the ReLU feature map (default 6x6, 32-bit words, row-major) through a synchronous read port. It writes the pooled map (default 3x3) through a write port and raises done. Both the convolution stage and the next stage use the same start/done handshake.

## Interface
- FM_WIDTH, 6, feature-map columns (>=2)
- FM_HEIGHT, 6, feature-map rows (>=2)
- DATA_W, 32, word width; values are signed two's complement
- RD_AW, 6, read address width; must satisfy 2^RD_AW >= FM_WIDTH*FM_HEIGHT
- WR_AW, 4, write address width; must satisfy 2^WR_AW >= (FM_WIDTH/2)*(FM_HEIGHT/2)
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  level; sampled only in IDLE and DONE
- fm_rd_en  output  1  read strobe to feature-map memory
- fm_rd_addr  output  RD_AW  row-major read address
- fm_rd_data  input  DATA_W  signed; valid exactly 1 cycle after fm_rd_en
- pool_wr_en  output  1  write strobe for the pooled result
- pool_wr_addr  output  WR_AW  row-major pooled address
- pool_wr_data  output  DATA_W  signed window maximum
- busy  output  1  high in every state except IDLE and DONE
- done  output  1  level; high in DONE

## Operation
- Output map is PW=FM_WIDTH/2 by PH=FM_HEIGHT/2, using floor division. If a dimension is odd, its last column or row is ignored.
- States:
  - IDLE: start=1 -> ISSUE.
  - ISSUE: 4 cycles, rd_cnt 0..3 -> LAST.
  - LAST: 1 cycle -> WRITE.
  - WRITE: 1 cycle -> ISSUE for the next window, or DONE after the final window.
  - DONE: start=1 -> ISSUE, restarting at window (0,0) and clearing done.
- Window (pr,pc) reads, in order: base, base+1, base+FM_WIDTH, base+FM_WIDTH+1, where base=2*pr*FM_WIDTH+2*pc.
- Running max:
  - The first returned sample loads max_reg unconditionally. It is never initialised to 0, so all-negative windows are pooled correctly.
  - Each later sample replaces max_reg when it is greater under signed comparison. Ties keep the current value.
- WRITE drives pool_wr_en=1, pool_wr_addr=pr*PW+pc, pool_wr_data=max_reg.
- Window order is row-major: pc increments; when pc==PW-1 it wraps to 0 and pr increments. The window with pr==PH-1 and pc==PW-1 is the final one.
- start while busy is ignored. start held high in IDLE or DONE begins a run, and a new run on every DONE entry while it stays high.
- There is no arithmetic. Data passes through unchanged, with width DATA_W.

## Timing
- Reset values: state=IDLE, fm_rd_en=0, fm_rd_addr=0, pool_wr_en=0, pool_wr_addr=0, pool_wr_data=0, busy=0, done=0. Internal pr, pc, rd_cnt and max_reg are all 0.
- All outputs are registered.
- Let C0 be the first cycle in which fm_rd_en=1. fm_rd_en becomes high on the edge that samples start.
- Window n:
  - reads in C0+6n .. C0+6n+3
  - captures data in C0+6n+1 .. C0+6n+4
  - has pool_wr_en=1 only in C0+6n+5
- fm_rd_en and pool_wr_en are never high in the same cycle. pool_wr_en is a single-cycle pulse per window.
- With defaults, the last write is in C0+53. done=1 and busy=0 from C0+54 onward, held until rst or a restart.
- Total run length: 6*PW*PH cycles of busy.
- rst mid-run: on the next edge all outputs return to their reset values. Any partial window is discarded with no write. start is not remembered.
- rst and start in the same cycle: rst wins.

## Test plan
- Ramp fm[i]=i for i=0..35, pulse start -> writes addresses 0..8 = 7,9,11,19,21,23,31,33,35 in order; done rises at C0+54.
- All words -5 except fm[14]=-3 -> pooled[4]=-3, every other output -5. This checks signed compare and first-sample load.
- Tie window 9,9,9,9 at window 0, and the maximum placed first, e.g. fm[0]=100 with others 1 -> pooled[0]=9 in the tie case and 100 in the max-first case.
- Assert rst at C0+20 -> next cycle all outputs are 0 and state is IDLE, with no further writes. A fresh start then reproduces the full ramp result.
- Pulse start at C0+10 and at C0+30 -> no effect on sequence or timing. Pulse start in DONE -> done falls, and a second identical run follows.
- Protocol checker across all tests:
  - fm_rd_addr < 36 whenever fm_rd_en=1
  - exactly 9 pool_wr_en pulses per run
  - fm_rd_en and pool_wr_en never high together
